// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//   Owns the program counter of the RV32I core and drives the combinational
//   instruction-memory read port. It fetches one word per cycle into a 2-entry
//   in-order buffer that feeds decode over a valid/ready handshake. Redirects
//   reload the PC and flush the buffer. Fetching stops after an EBREAK and
//   faults on a misaligned or out-of-range PC.
//
// Ports
//   clk, rst_n             clock, async active-low reset
//   start                  pulse: IDLE -> FETCH at the current PC
//   redirect, redirect_pc  load new PC, flush buffer (highest priority)
//   imem_addr / imem_instr memory read address (== PC) / returned word
//   out_valid/ready        decode handshake; out_instr/out_pc = head (0 if empty)
//   busy/halted/fault      state is FETCH / HALT / FAULT
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | reset state, waiting for start, no fetch
// ST_FETCH | one fetch per cycle while the buffer has room
// ST_HALT  | EBREAK pushed, fetch stopped, buffer keeps draining
// ST_FAULT | bad PC seen, fetch stopped, buffer keeps draining
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        busy,
    output logic        halted,
    output logic        fault
);

    localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * 4);
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HALT,
        ST_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fifo_pc    [2];
    logic [31:0] fifo_instr [2];
    logic        head_q;
    logic [1:0]  count_q, count_d;
    logic        push, pop, room, pc_bad, not_empty;
    logic        wr_idx;

    assign not_empty = (count_q != 2'd0);
    assign pc_bad    = (pc_q[1:0] != 2'b00) || (pc_q >= PC_LIMIT);
    assign out_valid = not_empty && !redirect;
    assign pop       = out_valid && out_ready;
    // A full buffer still has room when its head leaves this same cycle.
    assign room      = (count_q != 2'd2) || pop;
    // Tail slot; with count==2 this lands on the head slot being popped.
    assign wr_idx    = head_q ^ count_q[0];

    assign imem_addr = pc_q;
    assign out_instr = not_empty ? fifo_instr[head_q] : 32'h0;
    assign out_pc    = not_empty ? fifo_pc[head_q]    : 32'h0;
    assign busy      = (state_q == ST_FETCH);
    assign halted    = (state_q == ST_HALT);
    assign fault     = (state_q == ST_FAULT);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        if (redirect) begin
            state_d = ST_FETCH;
            pc_d    = redirect_pc;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (pc_bad) begin
                        state_d = ST_FAULT;
                    end else if (room) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                        if (imem_instr == EBREAK) state_d = ST_HALT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (redirect) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            count_q       <= 2'd0;
            head_q        <= 1'b0;
            fifo_pc[0]    <= 32'h0;
            fifo_pc[1]    <= 32'h0;
            fifo_instr[0] <= 32'h0;
            fifo_instr[1] <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            if (pop) head_q <= ~head_q;
            if (push) begin
                fifo_pc[wr_idx]    <= pc_q;
                fifo_instr[wr_idx] <= imem_instr;
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          MEM_WORDS = 64;
    localparam logic [31:0] LIMIT     = 32'(MEM_WORDS * 4);
    localparam logic [31:0] EBREAK    = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, redirect, out_ready;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_instr, out_instr, out_pc;
    logic        out_valid, busy, halted, fault;

    logic [31:0] mem [MEM_WORDS];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr < LIMIT) ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

    imem_fetch_ctrl #(.RESET_PC(RESET_PC), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .busy(busy), .halted(halted), .fault(fault)
    );

    // Reference model: a queue of (pc, word) pairs and a mode value.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    typedef enum {M_IDLE, M_FETCH, M_HALT, M_FAULT} mode_t;

    ent_t        q[$];
    mode_t       m_mode;
    logic [31:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc   = RESET_PC;
        m_mode = M_IDLE;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_addr"},   imem_addr, RESET_PC);
        chk({pfx, "_valid"},  32'(out_valid), 32'd0);
        chk({pfx, "_instr"},  out_instr, 32'd0);
        chk({pfx, "_pc"},     out_pc, 32'd0);
        chk({pfx, "_busy"},   32'(busy), 32'd0);
        chk({pfx, "_halted"}, 32'(halted), 32'd0);
        chk({pfx, "_fault"},  32'(fault), 32'd0);
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic s, input logic r, input logic [31:0] rp, input logic rdy);
        logic        e_valid, do_pop;
        logic [31:0] e_instr, e_pc;
        ent_t        e;
        @(negedge clk);
        start = s; redirect = r; redirect_pc = rp; out_ready = rdy;
        #1;
        e_valid = (q.size() > 0) && !r;
        e_instr = 32'd0;
        e_pc    = 32'd0;
        if (q.size() > 0) begin
            e_instr = q[0].instr;
            e_pc    = q[0].pc;
        end
        chk("addr",   imem_addr, m_pc);
        chk("valid",  32'(out_valid), 32'(e_valid));
        chk("instr",  out_instr, e_instr);
        chk("out_pc", out_pc, e_pc);
        chk("busy",   32'(busy),   32'(m_mode == M_FETCH));
        chk("halted", 32'(halted), 32'(m_mode == M_HALT));
        chk("fault",  32'(fault),  32'(m_mode == M_FAULT));

        do_pop = e_valid && rdy;
        if (r) begin
            q.delete();
            m_pc   = rp;
            m_mode = M_FETCH;
        end else begin
            if (do_pop) void'(q.pop_front());
            case (m_mode)
                M_IDLE: if (s) m_mode = M_FETCH;
                M_FETCH: begin
                    if ((m_pc % 4) != 0 || m_pc >= LIMIT) begin
                        m_mode = M_FAULT;
                    end else if (q.size() < 2) begin
                        e.pc    = m_pc;
                        e.instr = mem[m_pc / 4];
                        q.push_back(e);
                        m_pc = m_pc + 4;
                        if (e.instr == EBREAK) m_mode = M_HALT;
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        logic [31:0] rp;
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] = $urandom;
            if (mem[i] == EBREAK) mem[i] = mem[i] ^ 32'h1;
        end
        rst_n = 1'b0; start = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        model_reset();
        #12;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // idle, then sequential fetch with out_ready held high
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

        // backpressure from a redirect to 0
        step(0, 1, 32'h0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("bp_stall_addr", imem_addr, 32'd8);
        chk("bp_head_pc", out_pc, 32'd0);
        chk("bp_head_instr", out_instr, mem[0]);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

        // redirect with two words buffered
        step(0, 1, 32'h0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(0, 1, 32'h20, 1);
        chk("rd_valid_low", 32'(out_valid), 32'd0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rd_head_pc", out_pc, 32'h20);
        chk("rd_head_instr", out_instr, mem[8]);

        // EBREAK at word 3
        mem[3] = EBREAK;
        step(0, 1, 32'h0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
        chk("eb_halted", 32'(halted), 32'd1);
        chk("eb_addr", imem_addr, 32'd16);
        mem[3] = 32'h0000_0013;
        step(0, 1, 32'h0, 1);
        step(0, 0, 0, 1);
        chk("eb_resume_busy", 32'(busy), 32'd1);

        // faults: misaligned, out of range, last word then fault
        step(0, 1, 32'h102, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        chk("flt_mis", 32'(fault), 32'd1);
        chk("flt_mis_valid", 32'(out_valid), 32'd0);
        step(0, 1, LIMIT, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        chk("flt_range", 32'(fault), 32'd1);
        step(0, 1, LIMIT - 4, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("flt_last_pc", out_pc, LIMIT - 4);
        step(0, 0, 0, 1);
        chk("flt_last", 32'(fault), 32'd1);

        // reset mid-fetch
        step(0, 1, 32'h0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        // randomized traffic
        mem[40] = EBREAK;
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 9))
                0:       rp = 32'h102;
                1:       rp = LIMIT;
                default: rp = 32'($urandom_range(0, MEM_WORDS - 1)) * 4;
            endcase
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), rp,
                 ($urandom_range(0, 1) == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
